// File: rtl/updown_button_ctrl.sv
// Button conditioner: 2-FF sync + debounce per button, press FSM emitting E/U count strobes.
// Optional auto-repeat while held: define UPDOWN_BTN_AUTOREPEAT_EN.
module updown_button_ctrl #(
  parameter int unsigned DB_CYCLES  = 500000,
  parameter int unsigned REP_DELAY  = 25000000,
  parameter int unsigned REP_PERIOD = 5000000
) (
  input  logic Clk,
  input  logic Rst,
  input  logic BtnUp,
  input  logic BtnDn,
  output logic E,
  output logic U,
  output logic UpDb,
  output logic DnDb
);

  if (DB_CYCLES < 2 || REP_DELAY < 2 || REP_PERIOD < 2) begin : gen_param_check
    $error("updown_button_ctrl: DB_CYCLES, REP_DELAY and REP_PERIOD must be >= 2");
  end

  localparam int unsigned DbW = $clog2(DB_CYCLES + 1);
  localparam logic [DbW-1:0] DbLast = DbW'(DB_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StHoldUp, StHoldDn, StLock} state_e;

  // Bit 0 is the up button, bit 1 the down button.
  logic [1:0]     raw;
  logic [1:0]     sync1_q, sync2_q;
  logic [1:0]     db_q, db_d;
  logic [DbW-1:0] db_cnt_q [2];
  logic [DbW-1:0] db_cnt_d [2];

  state_e state_q, state_d;
  logic   e_q, u_q;
  logic   pulse, pulse_up;
  logic   up_db, dn_db;
  logic   rep_hit;

  assign raw   = {BtnDn, BtnUp};
  assign up_db = db_q[0];
  assign dn_db = db_q[1];

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      db_d[i]     = db_q[i];
      db_cnt_d[i] = '0;
      if (sync2_q[i] != db_q[i]) begin
        // Toggle on the DB_CYCLES-th differing cycle; >= keeps the count from wrapping.
        if (db_cnt_q[i] >= DbLast) begin
          db_d[i] = ~db_q[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + DbW'(1);
        end
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    pulse    = 1'b0;
    pulse_up = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (up_db && dn_db) begin
          state_d = StLock;
        end else if (up_db) begin
          state_d  = StHoldUp;
          pulse    = 1'b1;
          pulse_up = 1'b1;
        end else if (dn_db) begin
          state_d = StHoldDn;
          pulse   = 1'b1;
        end
      end
      StHoldUp: begin
        if (dn_db) begin
          state_d = StLock;
        end else if (!up_db) begin
          state_d = StIdle;
        end else if (rep_hit) begin
          pulse    = 1'b1;
          pulse_up = 1'b1;
        end
      end
      StHoldDn: begin
        if (up_db) begin
          state_d = StLock;
        end else if (!dn_db) begin
          state_d = StIdle;
        end else if (rep_hit) begin
          pulse = 1'b1;
        end
      end
      StLock: begin
        if (!up_db && !dn_db) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

`ifdef UPDOWN_BTN_AUTOREPEAT_EN
  localparam int unsigned RepMax = (REP_DELAY > REP_PERIOD) ? REP_DELAY : REP_PERIOD;
  localparam int unsigned RepW   = $clog2(RepMax + 1);

  logic [RepW-1:0] rep_cnt_q, rep_cnt_d;
  logic            rep_first_q, rep_first_d;
  logic            stay_hold;

  assign stay_hold = ((state_q == StHoldUp) || (state_q == StHoldDn)) && (state_d == state_q);
  // Counter restarts at every pulse; first interval is REP_DELAY, later ones REP_PERIOD.
  assign rep_hit   = rep_first_q ? (rep_cnt_q == RepW'(REP_PERIOD - 1))
                                 : (rep_cnt_q == RepW'(REP_DELAY - 1));

  always_comb begin
    rep_cnt_d   = '0;
    rep_first_d = 1'b0;
    if (stay_hold) begin
      if (rep_hit) begin
        rep_first_d = 1'b1;
      end else begin
        rep_cnt_d   = rep_cnt_q + RepW'(1);
        rep_first_d = rep_first_q;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      rep_cnt_q   <= '0;
      rep_first_q <= 1'b0;
    end else begin
      rep_cnt_q   <= rep_cnt_d;
      rep_first_q <= rep_first_d;
    end
  end
`else
  assign rep_hit = 1'b0;
`endif

  always_ff @(posedge Clk) begin
    if (Rst) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      db_q     <= '0;
      db_cnt_q <= '{default: '0};
      state_q  <= StIdle;
      e_q      <= 1'b0;
      u_q      <= 1'b1;
    end else begin
      sync1_q  <= raw;
      sync2_q  <= sync1_q;
      db_q     <= db_d;
      db_cnt_q <= db_cnt_d;
      state_q  <= state_d;
      e_q      <= pulse;
      if (pulse) begin
        u_q <= pulse_up;
      end
    end
  end

  assign E    = e_q;
  assign U    = u_q;
  assign UpDb = db_q[0];
  assign DnDb = db_q[1];

endmodule

// File: tb/tb_updown_button_ctrl.sv
// Randomized + directed bench for updown_button_ctrl against a behavioural press model.
module tb_updown_button_ctrl;

  localparam int unsigned DB = 4;
  localparam int unsigned RD = 10;
  localparam int unsigned RP = 3;

  localparam int MIdle = 0;
  localparam int MUp   = 1;
  localparam int MDn   = 2;
  localparam int MLock = 3;

  logic Clk = 1'b0;
  logic Rst, BtnUp, BtnDn;
  logic E, U, UpDb, DnDb;

  always #5 Clk = ~Clk;

  updown_button_ctrl #(
    .DB_CYCLES (DB),
    .REP_DELAY (RD),
    .REP_PERIOD(RP)
  ) dut (
    .Clk  (Clk),
    .Rst  (Rst),
    .BtnUp(BtnUp),
    .BtnDn(BtnDn),
    .E    (E),
    .U    (U),
    .UpDb (UpDb),
    .DnDb (DnDb)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Model: raw levels pass through two samples, then a run-length debounce, then press rules.
  bit [1:0] m_s1, m_s2, m_db;
  int       m_run [2];
  int       m_mode;
  int       m_age;
  bit       m_e, m_u;

  function automatic bit repeat_due(input int age);
`ifdef UPDOWN_BTN_AUTOREPEAT_EN
    return (age == RD) || (age > RD && ((age - RD) % RP) == 0);
`else
    return 1'b0;
`endif
  endfunction

  task automatic model_step(input bit up, input bit dn, input bit rst);
    bit old_up, old_dn, own, other;
    if (rst) begin
      m_s1 = '0; m_s2 = '0; m_db = '0;
      m_run[0] = 0; m_run[1] = 0;
      m_mode = MIdle; m_age = 0; m_e = 1'b0; m_u = 1'b1;
      return;
    end
    old_up = m_db[0];
    old_dn = m_db[1];
    m_e = 1'b0;
    if (m_mode == MIdle) begin
      if (old_up && old_dn) m_mode = MLock;
      else if (old_up) begin m_mode = MUp; m_age = 0; m_e = 1'b1; m_u = 1'b1; end
      else if (old_dn) begin m_mode = MDn; m_age = 0; m_e = 1'b1; m_u = 1'b0; end
    end else if (m_mode == MUp || m_mode == MDn) begin
      own   = (m_mode == MUp) ? old_up : old_dn;
      other = (m_mode == MUp) ? old_dn : old_up;
      if (other) m_mode = MLock;
      else if (!own) m_mode = MIdle;
      else begin
        m_age++;
        if (repeat_due(m_age)) begin m_e = 1'b1; m_u = (m_mode == MUp); end
      end
    end else begin
      if (!old_up && !old_dn) m_mode = MIdle;
    end
    for (int i = 0; i < 2; i++) begin
      if (m_s2[i] != m_db[i]) begin
        m_run[i]++;
        if (m_run[i] == int'(DB)) begin m_db[i] = ~m_db[i]; m_run[i] = 0; end
      end else begin
        m_run[i] = 0;
      end
    end
    m_s2 = m_s1;
    m_s1 = {dn, up};
  endtask

  int edge_cnt;
  int pulse_edges[$];
  bit pulse_dirs[$];

  task automatic mark();
    edge_cnt = 0;
    pulse_edges.delete();
    pulse_dirs.delete();
  endtask

  task automatic step(input bit up, input bit dn, input bit rst);
    BtnUp = up; BtnDn = dn; Rst = rst;
    @(posedge Clk);
    model_step(up, dn, rst);
    edge_cnt++;
    @(negedge Clk);
    check_eq("E", E, m_e);
    check_eq("U", U, m_u);
    check_eq("UpDb", UpDb, m_db[0]);
    check_eq("DnDb", DnDb, m_db[1]);
    if (E === 1'b1) begin
      pulse_edges.push_back(edge_cnt);
      pulse_dirs.push_back(U);
    end
  endtask

  task automatic hold(input bit up, input bit dn, input int n);
    for (int i = 0; i < n; i++) step(up, dn, 1'b0);
  endtask

  function automatic int first_edge();
    return (pulse_edges.size() > 0) ? pulse_edges[0] : -1;
  endfunction

  function automatic int first_dir();
    return (pulse_dirs.size() > 0) ? int'(pulse_dirs[0]) : -1;
  endfunction

  initial begin
    int exp_ar[8] = '{7, 17, 20, 23, 26, 29, 32, 35};
    mark();
    // Reset with both buttons held; down drops as reset releases, up stays held.
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 1'b1, 1'b1);
      check_eq("rst_E", E, 0);
      check_eq("rst_U", U, 1);
      check_eq("rst_db", {UpDb, DnDb}, 0);
    end
    mark();
    hold(1'b1, 1'b0, 20);
    hold(1'b0, 1'b0, 12);
    check_eq("rst_first_edge", first_edge(), 7);
`ifndef UPDOWN_BTN_AUTOREPEAT_EN
    check_eq("rst_pulse_cnt", pulse_edges.size(), 1);
`endif

    // Single up press.
    mark();
    hold(1'b1, 1'b0, 20);
    hold(1'b0, 1'b0, 12);
    check_eq("up_first_edge", first_edge(), 7);
    check_eq("up_dir", first_dir(), 1);
`ifndef UPDOWN_BTN_AUTOREPEAT_EN
    check_eq("up_pulse_cnt", pulse_edges.size(), 1);
`endif

    // Bounce on down: 1,1,0,0,1,1,0,0 then held; final rise sampled at edge 9.
    mark();
    for (int k = 0; k < 2; k++) begin
      hold(1'b0, 1'b1, 2);
      hold(1'b0, 1'b0, 2);
    end
    hold(1'b0, 1'b1, 16);
    hold(1'b0, 1'b0, 12);
    check_eq("bounce_first_edge", first_edge(), 15);
    check_eq("bounce_dir", first_dir(), 0);
`ifndef UPDOWN_BTN_AUTOREPEAT_EN
    check_eq("bounce_pulse_cnt", pulse_edges.size(), 1);
`endif

    // Simultaneous press locks out, then a clean down press works.
    mark();
    hold(1'b1, 1'b1, 16);
    hold(1'b0, 1'b0, 12);
    check_eq("simul_pulse_cnt", pulse_edges.size(), 0);
    mark();
    hold(1'b0, 1'b1, 16);
    hold(1'b0, 1'b0, 12);
    check_eq("after_lock_first_edge", first_edge(), 7);
    check_eq("after_lock_dir", first_dir(), 0);

    // Overlap: down pressed 8 cycles into an up hold.
    mark();
    hold(1'b1, 1'b0, 8);
    hold(1'b1, 1'b1, 16);
    hold(1'b0, 1'b0, 12);
    check_eq("overlap_pulse_cnt", pulse_edges.size(), 1);
    check_eq("overlap_first_edge", first_edge(), 7);
    check_eq("overlap_dir", first_dir(), 1);

`ifdef UPDOWN_BTN_AUTOREPEAT_EN
    mark();
    hold(1'b1, 1'b0, 30);
    hold(1'b0, 1'b0, 12);
    check_eq("ar_pulse_cnt", pulse_edges.size(), 8);
    for (int i = 0; i < 8; i++) begin
      check_eq($sformatf("ar_edge%0d", i), (i < pulse_edges.size()) ? pulse_edges[i] : -1,
               exp_ar[i]);
      check_eq($sformatf("ar_dir%0d", i), (i < pulse_dirs.size()) ? int'(pulse_dirs[i]) : -1,
               1);
    end
`else
    if (exp_ar[0] != 7) $display("unexpected table");
`endif

    // Random segments, including short glitches and occasional mid-press resets.
    for (int s = 0; s < 160; s++) begin
      bit up, dn;
      int len;
      up  = 1'($urandom_range(0, 1));
      dn  = ($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0;
      if ($urandom_range(0, 1) == 0) begin
        bit t;
        t = up; up = dn; dn = t;
      end
      len = $urandom_range(1, 14);
      if ($urandom_range(0, 24) == 0) begin
        for (int r = 0; r < int'($urandom_range(1, 2)); r++) step(up, dn, 1'b1);
      end
      hold(up, dn, len);
    end
    hold(1'b0, 1'b0, 14);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
